// File: rtl/morse_pkg.sv
// ============================================================================
// Module : morse_pkg
// Brief  : State encoding and constant helpers shared by the Morse sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int MS_CNT_W = 16;

    function automatic int ms_cycles(input int ms, input int clk_hz);
        return ms * (clk_hz / 1000);
    endfunction

    function automatic int len_w(input int max_elem);
        return $clog2(max_elem + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_ms_timer.sv
// ============================================================================
// Module : morse_ms_timer
// Brief  : Millisecond prescaler plus ms counter; expire pulses on the last
//          cycle of a target_ms interval. clr restarts both counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module morse_ms_timer
    import morse_pkg::*;
#(
    parameter int MS_CYC = 50_000
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                clr,
    input  logic                en,
    input  logic [MS_CNT_W-1:0] target_ms,
    output logic                expire
);

    localparam int PRE_W = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam logic [PRE_W-1:0]    c_PRE_LAST = PRE_W'(MS_CYC - 1);
    localparam logic [MS_CNT_W-1:0] c_MS_ONE   = MS_CNT_W'(1);

    logic [PRE_W-1:0]    r_pre;
    logic [MS_CNT_W-1:0] r_ms;
    logic                w_ms_tick;

    assign w_ms_tick = (r_pre == c_PRE_LAST);

    // expire must not depend on clr: the sequencer derives clr from expire
    assign expire = en && w_ms_tick && (r_ms == (target_ms - c_MS_ONE));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (clr) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (en) begin
            if (w_ms_tick) begin
                r_pre <= '0;
                r_ms  <= r_ms + c_MS_ONE;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/morse_seq_gen.sv
// ============================================================================
// Module : morse_seq_gen
// Brief  : Plays up to MAX_ELEM dot/dash elements on an active-low buzzer pin.
//          Optional macro MORSE_TONE_EN: square tone during ON (passive buzzer).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module morse_seq_gen
    import morse_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int MAX_ELEM = 9,
    parameter int DOT_MS   = 100,
    parameter int DASH_MS  = 400,
    parameter int GAP_MS   = 50,
    parameter int TONE_DIV = 12_500
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic                         start_sig,
    input  logic                         abort_sig,
    input  logic [MAX_ELEM-1:0]          pattern,
    input  logic [len_w(MAX_ELEM)-1:0]   pat_len,
    output logic                         busy,
    output logic                         done_sig,
    output logic                         pin_out
);

    localparam int LEN_W = len_w(MAX_ELEM);
    localparam logic [LEN_W-1:0]    c_MAX_LEN = LEN_W'(MAX_ELEM);
    localparam logic [LEN_W-1:0]    c_IDX_ONE = LEN_W'(1);
    localparam logic [MS_CNT_W-1:0] c_DOT_MS  = MS_CNT_W'(DOT_MS);
    localparam logic [MS_CNT_W-1:0] c_DASH_MS = MS_CNT_W'(DASH_MS);
    localparam logic [MS_CNT_W-1:0] c_GAP_MS  = MS_CNT_W'(GAP_MS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MAX_ELEM-1:0] r_pat;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    w_idx_inc;
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_latch;
    logic                w_adv;
    logic                w_expire;
    logic                w_tmr_en;
    logic                w_tmr_clr;
    logic                w_cur_dash;
    logic [MS_CNT_W-1:0] w_target_ms;

    assign w_idx_inc     = r_idx + c_IDX_ONE;
    assign w_len_clamped = (pat_len > c_MAX_LEN) ? c_MAX_LEN : pat_len;
    assign w_cur_dash    = r_pat[r_idx];

    // Restarting the timer on every state entry keeps each interval exact
    assign w_tmr_en    = (r_state == S_ON) || (r_state == S_OFF);
    assign w_tmr_clr   = !w_tmr_en || w_expire;
    assign w_target_ms = (r_state == S_ON) ? (w_cur_dash ? c_DASH_MS : c_DOT_MS) : c_GAP_MS;

    morse_ms_timer #(
        .MS_CYC (ms_cycles(1, CLK_HZ))
    ) u_timer (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .clr       (w_tmr_clr),
        .en        (w_tmr_en),
        .target_ms (w_target_ms),
        .expire    (w_expire)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_pat <= pattern;
                r_len <= w_len_clamped;
                r_idx <= '0;
            end else if (w_adv) begin
                r_idx <= w_idx_inc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_sig && !abort_sig) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (w_len_clamped != '0) ? S_ON : S_DONE;
                end
            end
            S_ON: begin
                if (abort_sig)     w_state_nxt = S_IDLE;
                else if (w_expire) w_state_nxt = S_OFF;
            end
            S_OFF: begin
                if (abort_sig) begin
                    w_state_nxt = S_IDLE;
                end else if (w_expire) begin
                    if (w_idx_inc == r_len) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ON;
                        w_adv       = 1'b1;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign done_sig = (r_state == S_DONE);

`ifdef MORSE_TONE_EN
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TONE_W-1:0] c_TONE_LAST = TONE_W'(TONE_DIV - 1);

    logic [TONE_W-1:0] r_tone_cnt;
    logic              r_tone;

    // Phase counter idles at zero outside ON so every element starts low
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (r_state != S_ON) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (r_tone_cnt == c_TONE_LAST) begin
            r_tone_cnt <= '0;
            r_tone     <= ~r_tone;
        end else begin
            r_tone_cnt <= r_tone_cnt + TONE_W'(1);
        end
    end

    assign pin_out = (r_state == S_ON) ? r_tone : 1'b1;
`else
    assign pin_out = (r_state != S_ON);
`endif

endmodule

`default_nettype wire

// File: tb/tb_morse_seq_gen.sv
// Scoreboard bench for morse_seq_gen: dot 20, dash 60, gap 10 cycles.
`default_nettype none

module tb_morse_seq_gen;

    localparam int DOT     = 20;
    localparam int DASH    = 60;
    localparam int GAP     = 10;
    localparam int K_ON    = 0;
    localparam int K_GAP   = 1;
    localparam int K_DONE  = 2;
    localparam int K_ABORT = 3;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       start_sig = 1'b0;
    logic       abort_sig = 1'b0;
    logic [8:0] pattern = '0;
    logic [3:0] pat_len = '0;
    logic       busy;
    logic       done_sig;
    logic       pin_out;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int run_kind = -1;
    int run_len  = 0;
    int cur_kind;

    morse_seq_gen #(
        .CLK_HZ   (10_000),
        .MAX_ELEM (9),
        .DOT_MS   (2),
        .DASH_MS  (6),
        .GAP_MS   (1),
        .TONE_DIV (5)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start_sig (start_sig),
        .abort_sig (abort_sig),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .busy      (busy),
        .done_sig  (done_sig),
        .pin_out   (pin_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Event code = kind*1000 + run length
    task automatic emit(input int kind, input int len);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got %0d want none at %0t", kind * 1000 + len, $time);
        end else begin
            chk("event", kind * 1000 + len, exp_q.pop_front());
        end
    endtask

    // Monitor: turns pin/busy/done activity into ON/GAP/DONE/ABORT events
    always @(negedge CLK) begin
        if (busy && !done_sig) begin
            cur_kind = pin_out ? K_GAP : K_ON;
            if (run_kind == cur_kind) begin
                run_len++;
            end else begin
                if (run_kind >= 0) emit(run_kind, run_len);
                run_kind = cur_kind;
                run_len  = 1;
            end
        end else if (done_sig) begin
            if (run_kind >= 0) emit(run_kind, run_len);
            run_kind = -1;
            chk("done_pin", pin_out, 1);
            emit(K_DONE, 0);
        end else begin
            if (run_kind >= 0) emit(K_ABORT, 0);
            run_kind = -1;
            chk("idle_pin", pin_out, 1);
        end
    end

    task automatic push_seq(input logic [8:0] p, input int n);
        int m;
        m = (n > 9) ? 9 : n;
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(K_ON * 1000 + (p[i] ? DASH : DOT));
            exp_q.push_back(K_GAP * 1000 + GAP);
        end
        exp_q.push_back(K_DONE * 1000);
    endtask

    task automatic pulse_start(input logic [8:0] p, input logic [3:0] n, input logic ab);
        pattern   = p;
        pat_len   = n;
        start_sig = 1'b1;
        abort_sig = ab;
        @(posedge CLK);
        #1;
        start_sig = 1'b0;
        abort_sig = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        while (busy && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        chk(nm, busy, 0);
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int bc;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done_sig, 0);
        chk("rst_pin", pin_out, 1);
        RSTn = 1'b1;
        @(negedge CLK);

        // SOS with exact latency and completion cycle
        push_seq(9'b000_111_000, 9);
        pulse_start(9'b000_111_000, 4'd9, 1'b0);
        @(negedge CLK);
        chk("lat_pin", pin_out, 0);
        chk("lat_busy", busy, 1);
        j = 1;
        while (!done_sig && j < 1000) begin
            @(negedge CLK);
            j++;
        end
        chk("sos_done_cycle", j, 391);
        @(negedge CLK);
        chk("sos_busy_low", busy, 0);
        wait_idle("sos_idle");

        // Zero-length sequence: straight to DONE
        push_seq(9'h1FF, 0);
        pulse_start(9'h1FF, 4'd0, 1'b0);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (busy) bc++;
        end
        chk("len0_busy_cycles", bc, 1);

        // Length above MAX_ELEM clamps to 9
        push_seq(9'h155, 12);
        pulse_start(9'h155, 4'd12, 1'b0);
        wait_idle("clamp_idle");

        // Start while busy and pattern change mid-sequence are ignored
        push_seq(9'b101, 3);
        pulse_start(9'b101, 4'd3, 1'b0);
        repeat (30) @(negedge CLK);
        pulse_start(9'h1FF, 4'd9, 1'b0);
        pattern = 9'h0AA;
        pat_len = 4'd2;
        wait_idle("busy_start_idle");

        // Abort during the 2nd gap (cycles 51..60)
        exp_q.push_back(K_ON * 1000 + DOT);
        exp_q.push_back(K_GAP * 1000 + GAP);
        exp_q.push_back(K_ON * 1000 + DOT);
        exp_q.push_back(K_ABORT * 1000);
        pulse_start(9'b000, 4'd3, 1'b0);
        repeat (54) @(negedge CLK);
        abort_sig = 1'b1;
        @(posedge CLK);
        #1;
        abort_sig = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pin", pin_out, 1);
        chk("abort_done", done_sig, 0);
        repeat (5) @(negedge CLK);

        // Later start plays from element 0
        push_seq(9'b110, 3);
        pulse_start(9'b110, 4'd3, 1'b0);
        wait_idle("restart_idle");

        // Abort and start together mid-sequence
        exp_q.push_back(K_ABORT * 1000);
        pulse_start(9'b000, 4'd1, 1'b0);
        repeat (5) @(negedge CLK);
        pulse_start(9'h1FF, 4'd9, 1'b1);
        chk("abort_start_busy", busy, 0);
        repeat (5) @(negedge CLK);
        chk("abort_start_stay_idle", busy, 0);

        // Abort and start together in IDLE: abort wins
        pulse_start(9'h1FF, 4'd9, 1'b1);
        chk("idle_abort_start_busy", busy, 0);
        repeat (3) @(negedge CLK);

        // Asynchronous reset during a dash
        exp_q.push_back(K_ON * 1000 + DOT);
        exp_q.push_back(K_GAP * 1000 + GAP);
        exp_q.push_back(K_ABORT * 1000);
        pulse_start(9'b10, 4'd2, 1'b0);
        repeat (40) @(negedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pin", pin_out, 1);
        chk("arst_done", done_sig, 0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (5) @(negedge CLK);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
